// File: rtl/cache_line_mem.sv
// One way of the direct-mapped cache: per-set tag/valid storage, multi-word data lines with
// per-byte store enables, a burst line-fill engine and a sequential invalidate walker.
// Optional macro CACHE_MEM_BYPASS_EN: forward a same-cycle store or fill beat to the read port.
module cache_line_mem #(
    parameter int unsigned INDEX_WIDTH  = 6,
    parameter int unsigned OFFSET_WIDTH = 3,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned TAG_WIDTH    = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [INDEX_WIDTH-1:0]    rd_index,
    input  logic [OFFSET_WIDTH-1:0]   rd_offset,
    input  logic [TAG_WIDTH-1:0]      rd_tag,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_hit,
    input  logic                      wr_en,
    input  logic [INDEX_WIDTH-1:0]    wr_index,
    input  logic [OFFSET_WIDTH-1:0]   wr_offset,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_be,
    input  logic                      fill_start,
    input  logic [INDEX_WIDTH-1:0]    fill_index,
    input  logic [TAG_WIDTH-1:0]      fill_tag,
    input  logic                      fill_valid,
    input  logic [DATA_WIDTH-1:0]     fill_data,
    output logic                      fill_done,
    input  logic                      flush_start,
    output logic                      busy
);

    localparam int unsigned SETS       = 1 << INDEX_WIDTH;
    localparam int unsigned WORDS      = 1 << OFFSET_WIDTH;
    localparam int unsigned BYTES      = DATA_WIDTH / 8;
    localparam int unsigned ADDR_WIDTH = INDEX_WIDTH + OFFSET_WIDTH;

    typedef enum logic [1:0] {StClear, StIdle, StFill} state_e;

    state_e                   state_q;
    logic [INDEX_WIDTH-1:0]   ctr_q;
    logic [INDEX_WIDTH-1:0]   fill_idx_q;
    logic [TAG_WIDTH-1:0]     fill_tag_q;
    logic [OFFSET_WIDTH-1:0]  beat_q;
    logic [SETS-1:0]          valid_q;

    logic [TAG_WIDTH-1:0]     tag_mem [SETS];
    logic [DATA_WIDTH-1:0]    mem     [SETS*WORDS];

    logic                     wr_accept;
    logic                     beat_accept;
    logic                     last_beat;
    logic [ADDR_WIDTH-1:0]    waddr;
    logic [ADDR_WIDTH-1:0]    raddr;
    logic [BYTES-1:0]         wbe;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [DATA_WIDTH-1:0]    rd_word;

    assign busy = (state_q != StIdle);

    // Shared array write port: a fill beat and a store can never coincide (FILL vs IDLE).
    always_comb begin
        wr_accept   = rst_n && wr_en && (state_q == StIdle);
        beat_accept = rst_n && fill_valid && (state_q == StFill);
        last_beat   = beat_accept && (&beat_q);
        raddr       = {rd_index, rd_offset};
        waddr       = {wr_index, wr_offset};
        wdata       = wr_data;
        wbe         = '0;
        if (beat_accept) begin
            waddr = {fill_idx_q, beat_q};
            wdata = fill_data;
            wbe   = '1;
        end else if (wr_accept) begin
            wbe = wr_be;
        end
    end

    // Next read word: old contents, optionally merged with a same-cycle write to that word.
    always_comb begin
        rd_word = mem[raddr];
`ifdef CACHE_MEM_BYPASS_EN
        if (waddr == raddr) begin
            for (int unsigned k = 0; k < BYTES; k++) begin
                if (wbe[k]) rd_word[8*k +: 8] = wdata[8*k +: 8];
            end
        end
`else
`endif
    end

    // Data array: byte-granular writes, never reset.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < BYTES; k++) begin
            if (wbe[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
        end
    end

    // Tag array: written only when the last beat of a fill lands.
    always_ff @(posedge clk) begin
        if (last_beat) tag_mem[fill_idx_q] <= fill_tag_q;
    end

    // Control FSM, valid bits and registered read/fill outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StClear;
            ctr_q      <= '0;
            beat_q     <= '0;
            fill_idx_q <= '0;
            fill_tag_q <= '0;
            rd_data    <= '0;
            rd_hit     <= 1'b0;
            fill_done  <= 1'b0;
        end else begin
            rd_data   <= rd_word;
            rd_hit    <= valid_q[rd_index] && (tag_mem[rd_index] == rd_tag) && !busy;
            fill_done <= 1'b0;
            case (state_q)
                StClear: begin
                    valid_q[ctr_q] <= 1'b0;
                    ctr_q          <= ctr_q + 1'b1;
                    if (&ctr_q) state_q <= StIdle;
                end
                StIdle: begin
                    // Flush takes priority over a simultaneous fill request.
                    if (flush_start) begin
                        state_q <= StClear;
                        ctr_q   <= '0;
                    end else if (fill_start) begin
                        state_q             <= StFill;
                        fill_idx_q          <= fill_index;
                        fill_tag_q          <= fill_tag;
                        valid_q[fill_index] <= 1'b0;
                        beat_q              <= '0;
                    end
                end
                StFill: begin
                    if (fill_valid) begin
                        beat_q <= beat_q + 1'b1;
                        if (&beat_q) begin
                            valid_q[fill_idx_q] <= 1'b1;
                            fill_done           <= 1'b1;
                            state_q             <= StIdle;
                        end
                    end
                end
                default: state_q <= StClear;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_mem.sv
// Self-checking bench for cache_line_mem (default parameters): table-driven lookups through a
// scoreboard queue plus hand-written fill / store / reset / flush sequences.
module tb_cache_line_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  rd_index;
    logic [2:0]  rd_offset;
    logic [19:0] rd_tag;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic        wr_en;
    logic [5:0]  wr_index;
    logic [2:0]  wr_offset;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        fill_start;
    logic [5:0]  fill_index;
    logic [19:0] fill_tag;
    logic        fill_valid;
    logic [31:0] fill_data;
    logic        fill_done;
    logic        flush_start;
    logic        busy;

    cache_line_mem dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_index    (rd_index),
        .rd_offset   (rd_offset),
        .rd_tag      (rd_tag),
        .rd_data     (rd_data),
        .rd_hit      (rd_hit),
        .wr_en       (wr_en),
        .wr_index    (wr_index),
        .wr_offset   (wr_offset),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .fill_start  (fill_start),
        .fill_index  (fill_index),
        .fill_tag    (fill_tag),
        .fill_valid  (fill_valid),
        .fill_data   (fill_data),
        .fill_done   (fill_done),
        .flush_start (flush_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;

    // Count cycles in which fill_done is high.
    always @(negedge clk) begin
        if (fill_done === 1'b1) fd_count <= fd_count + 1;
    end

    typedef struct {
        logic [5:0]  idx;
        logic [2:0]  off;
        logic [19:0] tag;
        logic [31:0] data;
        logic        hit;
        bit          chk_data;
    } lookup_t;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        hit;
        bit          chk_data;
    } exp_t;

    exp_t sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive a lookup, queue its expectation, then compare once the registered result appears.
    task automatic do_read(input string name, input logic [5:0] idx, input logic [2:0] off,
                           input logic [19:0] tag, input logic [31:0] data, input logic hit,
                           input bit chk_data);
        exp_t e;
        rd_index   = idx;
        rd_offset  = off;
        rd_tag     = tag;
        e.name     = name;
        e.data     = data;
        e.hit      = hit;
        e.chk_data = chk_data;
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        check({e.name, ".hit"}, {31'd0, rd_hit}, {31'd0, e.hit});
        if (e.chk_data) check({e.name, ".data"}, rd_data, e.data);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check(name, n, 64);
    endtask

    // Back-to-back fill; optionally present a store in the first FILL cycle (must be dropped).
    task automatic fill_line(input string name, input logic [5:0] idx, input logic [19:0] tag,
                             input logic [31:0] base, input bit store_first);
        fill_start = 1'b1;
        fill_index = idx;
        fill_tag   = tag;
        tick();
        fill_start = 1'b0;
        check({name, ".busy"}, {31'd0, busy}, 32'd1);
        if (store_first) begin
            wr_en     = 1'b1;
            wr_index  = 6'd5;
            wr_offset = 3'd2;
            wr_data   = 32'h0;
            wr_be     = 4'hF;
            tick();
            wr_en     = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            fill_valid = 1'b1;
            fill_data  = base + i;
            tick();
        end
        fill_valid = 1'b0;
        check({name, ".fill_done"}, {31'd0, fill_done}, 32'd1);
        check({name, ".busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    lookup_t lk[6];
    int      fd0;

    initial begin
        lk[0] = '{idx: 6'd5, off: 3'd0, tag: 20'hABCDE, data: 32'h100, hit: 1'b1, chk_data: 1'b1};
        lk[1] = '{idx: 6'd5, off: 3'd7, tag: 20'hABCDE, data: 32'h107, hit: 1'b1, chk_data: 1'b1};
        lk[2] = '{idx: 6'd5, off: 3'd3, tag: 20'hABCDF, data: 32'h103, hit: 1'b0, chk_data: 1'b1};
        lk[3] = '{idx: 6'd5, off: 3'd4, tag: 20'h00000, data: 32'h104, hit: 1'b0, chk_data: 1'b1};
        lk[4] = '{idx: 6'd4, off: 3'd0, tag: 20'hABCDE, data: 32'h0,   hit: 1'b0, chk_data: 1'b0};
        lk[5] = '{idx: 6'd6, off: 3'd1, tag: 20'h00000, data: 32'h0,   hit: 1'b0, chk_data: 1'b0};

        rst_n = 1'b0;
        rd_index = '0; rd_offset = '0; rd_tag = '0;
        wr_en = 1'b0; wr_index = '0; wr_offset = '0; wr_data = '0; wr_be = '0;
        fill_start = 1'b0; fill_index = '0; fill_tag = '0; fill_valid = 1'b0; fill_data = '0;
        flush_start = 1'b0;
        repeat (3) tick();

        // Reset values and initial CLEAR walk.
        check("reset.busy", {31'd0, busy}, 32'd1);
        check("reset.rd_hit", {31'd0, rd_hit}, 32'd0);
        check("reset.rd_data", rd_data, 32'd0);
        check("reset.fill_done", {31'd0, fill_done}, 32'd0);
        rst_n = 1'b1;
        wait_idle("reset.clear_cycles");
        do_read("post_reset.set0", 6'd0, 3'd0, 20'h0, 32'h0, 1'b0, 1'b0);
        do_read("post_reset.set5", 6'd5, 3'd0, 20'h0, 32'h0, 1'b0, 1'b0);
        do_read("post_reset.set63", 6'd63, 3'd7, 20'h0, 32'h0, 1'b0, 1'b0);

        // Fill set 5 with a two-cycle gap after beat 3; lookups in the gap must miss.
        fill_start = 1'b1;
        fill_index = 6'd5;
        fill_tag   = 20'hABCDE;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fill_valid = 1'b1;
            fill_data  = 32'h100 + i;
            tick();
            fill_valid = 1'b0;
            if (i == 3) begin
                do_read("fill.gap_miss0", 6'd5, 3'd0, 20'hABCDE, 32'h100, 1'b0, 1'b1);
                do_read("fill.gap_miss1", 6'd5, 3'd3, 20'hABCDE, 32'h103, 1'b0, 1'b1);
            end
        end
        check("fill.done_pulse", {31'd0, fill_done}, 32'd1);
        do_read("fill.hit_in_done_cycle", 6'd5, 3'd6, 20'hABCDE, 32'h106, 1'b1, 1'b1);
        check("fill.done_one_cycle", {31'd0, fill_done}, 32'd0);
        check("fill.done_count", fd_count, 32'd1);

        for (int i = 0; i < 6; i++) begin
            do_read($sformatf("lookup[%0d]", i), lk[i].idx, lk[i].off, lk[i].tag, lk[i].data,
                    lk[i].hit, lk[i].chk_data);
        end

        // Same-cycle store and read of (5,2), byte enables 0101 over 0x102.
        wr_en     = 1'b1;
        wr_index  = 6'd5;
        wr_offset = 3'd2;
        wr_data   = 32'hFFFF_FFFF;
        wr_be     = 4'b0101;
`ifdef CACHE_MEM_BYPASS_EN
        do_read("store.same_cycle", 6'd5, 3'd2, 20'hABCDE, 32'h00FF_01FF, 1'b1, 1'b1);
`else
        do_read("store.same_cycle", 6'd5, 3'd2, 20'hABCDE, 32'h0000_0102, 1'b1, 1'b1);
`endif
        wr_en = 1'b0;
        do_read("store.merged", 6'd5, 3'd2, 20'hABCDE, 32'h00FF_01FF, 1'b1, 1'b1);

        // Store during FILL is dropped.
        fill_line("fill7", 6'd7, 20'h11111, 32'h700, 1'b1);
        do_read("store.dropped_in_fill", 6'd5, 3'd2, 20'hABCDE, 32'h00FF_01FF, 1'b1, 1'b1);
        do_read("fill7.hit", 6'd7, 3'd1, 20'h11111, 32'h701, 1'b1, 1'b1);

        // Reset during beat 4 of a fill of set 9 abandons it.
        fill_line("fill9", 6'd9, 20'h99999, 32'h900, 1'b0);
        do_read("fill9.hit", 6'd9, 3'd0, 20'h99999, 32'h900, 1'b1, 1'b1);
        #20;
        fd0 = fd_count;
        fill_start = 1'b1;
        fill_index = 6'd9;
        fill_tag   = 20'h12345;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fill_valid = 1'b1;
            fill_data  = 32'hA00 + i;
            tick();
        end
        fill_valid = 1'b1;
        fill_data  = 32'hA04;
        rst_n      = 1'b0;
        tick();
        fill_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_idle("midfill_reset.clear_cycles");
        check("midfill_reset.no_done", fd_count, fd0);
        do_read("midfill_reset.new_tag_miss", 6'd9, 3'd0, 20'h12345, 32'h0, 1'b0, 1'b0);
        do_read("midfill_reset.old_tag_miss", 6'd9, 3'd0, 20'h99999, 32'h0, 1'b0, 1'b0);

        // Flush and fill requested together: flush wins.
        fill_line("refill5", 6'd5, 20'hABCDE, 32'h500, 1'b0);
        fill_line("refill9", 6'd9, 20'h99999, 32'h900, 1'b0);
        do_read("preflush.hit5", 6'd5, 3'd0, 20'hABCDE, 32'h500, 1'b1, 1'b1);
        do_read("preflush.hit9", 6'd9, 3'd3, 20'h99999, 32'h903, 1'b1, 1'b1);
        #20;
        fd0 = fd_count;
        flush_start = 1'b1;
        fill_start  = 1'b1;
        fill_index  = 6'd3;
        fill_tag    = 20'h33333;
        tick();
        flush_start = 1'b0;
        fill_start  = 1'b0;
        wait_idle("flush.clear_cycles");
        check("flush.no_fill_done", fd_count, fd0);
        // Beats outside FILL must not write the last fill target.
        for (int i = 0; i < 8; i++) begin
            fill_valid = 1'b1;
            fill_data  = 32'hDEAD_0000 + i;
            tick();
        end
        fill_valid = 1'b0;
        check("flush.still_idle", {31'd0, busy}, 32'd0);
        do_read("flush.miss5", 6'd5, 3'd0, 20'hABCDE, 32'h500, 1'b0, 1'b1);
        do_read("flush.miss9", 6'd9, 3'd3, 20'h99999, 32'h903, 1'b0, 1'b1);
        do_read("flush.miss7", 6'd7, 3'd1, 20'h11111, 32'h701, 1'b0, 1'b1);
        do_read("flush.miss3", 6'd3, 3'd0, 20'h33333, 32'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
